// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sched_pkg
//  Description : Shared types, default sizes and helpers for the output byte
//                FIFO write/read sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_sched_pkg;

    // Default sizing of the decompressor output FIFO path
    localparam int DEF_FIFO_SIZE    = 128;
    localparam int DEF_MAX_BYTES_IN = 16;
    localparam int DEF_MAX_BURST    = 32;

    // Counter widths: each holds its maximum value (not just max-1)
    localparam int BURST_LEN_W = $clog2(DEF_MAX_BURST + 1);
    localparam int CHUNK_W     = $clog2(DEF_MAX_BYTES_IN + 1);
    localparam int OCC_W       = $clog2(DEF_FIFO_SIZE + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } sched_state_t;

    // Size of the next chunk: whatever is left, capped by the FIFO port width
    function automatic int unsigned min_chunk(input int unsigned remaining,
                                              input int unsigned limit = DEF_MAX_BYTES_IN);
        return (remaining < limit) ? remaining : limit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_lane_shift.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_lane_shift
//  Description : Selects MAX_BYTES_IN byte lanes of a burst starting at a byte
//                offset; lanes at or beyond the chunk size are forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_lane_shift #(
    parameter int MAX_BURST    = 32,
    parameter int MAX_BYTES_IN = 16
) (
    input  logic [8*MAX_BURST-1:0]            data_i,
    input  logic [$clog2(MAX_BURST+1)-1:0]    offset_i,
    input  logic [$clog2(MAX_BYTES_IN+1)-1:0] chunk_i,
    output logic [8*MAX_BYTES_IN-1:0]         lanes_o
);

    localparam int c_OUT_W = 8 * MAX_BYTES_IN;

    logic [c_OUT_W-1:0] w_win;

    // Byte-granular right shift so that burst byte 'offset' lands in lane 0
    assign w_win = c_OUT_W'(data_i >> {offset_i, 3'b000});

    for (genvar i = 0; i < MAX_BYTES_IN; i++) begin : g_lane
        assign lanes_o[8*i +: 8] = (i < int'(chunk_i)) ? w_win[8*i +: 8] : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_sched
//  Description : Splits upstream byte bursts into FIFO-port-sized chunks,
//                issues a chunk only when the FIFO has room, tracks a shadow
//                occupancy and gates consumer reads against underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_sched
    import fifo_sched_pkg::*;
#(
    parameter int FIFO_SIZE    = DEF_FIFO_SIZE,
    parameter int MAX_BYTES_IN = DEF_MAX_BYTES_IN,
    parameter int MAX_BURST    = DEF_MAX_BURST
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [8*MAX_BURST-1:0]              burst_data_in,
    input  logic [$clog2(MAX_BURST+1)-1:0]      burst_len_in,
    input  logic                                burst_valid_in,
    output logic                                burst_ready_out,
    output logic [8*MAX_BYTES_IN-1:0]           fifo_data_out,
    output logic [$clog2(MAX_BYTES_IN+1)-1:0]   fifo_num_bytes_out,
    output logic                                fifo_wr_en_out,
    input  logic                                rd_req_in,
    output logic                                fifo_rd_en_out,
    output logic [$clog2(FIFO_SIZE+1)-1:0]      occupancy_out,
    output logic                                busy_out
);

    localparam int c_LEN_W = $clog2(MAX_BURST + 1);
    localparam int c_NB_W  = $clog2(MAX_BYTES_IN + 1);
    localparam int c_OCC_W = $clog2(FIFO_SIZE + 1);

    sched_state_t               state_q;
    logic [c_LEN_W-1:0]         remaining_q;
    logic [c_LEN_W-1:0]         offset_q;
    logic [8*MAX_BURST-1:0]     data_q;
    logic [c_OCC_W-1:0]         occupancy_q;
    logic [c_OCC_W-1:0]         occupancy_d;

    logic [c_NB_W-1:0]          w_chunk;
    logic [c_OCC_W-1:0]         w_free;
    logic                       w_wr_en;
    logic                       w_rd_en;

    // remaining_q is zero outside WRITE, so w_chunk is zero there as well
    assign w_chunk = c_NB_W'(min_chunk(32'(remaining_q), MAX_BYTES_IN));
    // Free space uses the registered count; a read in this cycle is not credited
    assign w_free  = c_OCC_W'(FIFO_SIZE) - occupancy_q;
    assign w_wr_en = (state_q == WRITE) && (c_OCC_W'(w_chunk) <= w_free);
    assign w_rd_en = rd_req_in && (occupancy_q != '0);

    assign burst_ready_out    = (state_q == IDLE);
    assign busy_out           = (state_q == WRITE);
    assign fifo_wr_en_out     = w_wr_en;
    assign fifo_num_bytes_out = w_wr_en ? w_chunk : '0;
    assign fifo_rd_en_out     = w_rd_en;
    assign occupancy_out      = occupancy_q;

    // A stalled or idle cycle passes chunk 0, which blanks every lane
    chunk_lane_shift #(
        .MAX_BURST    (MAX_BURST),
        .MAX_BYTES_IN (MAX_BYTES_IN)
    ) u_lane_shift (
        .data_i   (data_q),
        .offset_i (offset_q),
        .chunk_i  (fifo_num_bytes_out),
        .lanes_o  (fifo_data_out)
    );

    // Burst acceptance and chunk sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            offset_q    <= '0;
            data_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Zero-length bursts are accepted and simply dropped
                    if (burst_valid_in && (burst_len_in != '0)) begin
                        data_q      <= burst_data_in;
                        remaining_q <= burst_len_in;
                        offset_q    <= '0;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_wr_en) begin
                        offset_q    <= offset_q + c_LEN_W'(w_chunk);
                        remaining_q <= remaining_q - c_LEN_W'(w_chunk);
                        if (remaining_q == c_LEN_W'(w_chunk)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Writes and reads in the same cycle are both applied
    assign occupancy_d = occupancy_q
                       + (w_wr_en ? c_OCC_W'(w_chunk) : '0)
                       - (w_rd_en ? c_OCC_W'(1) : '0);

    // Shadow occupancy of the downstream FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (!reset)
        int'(occupancy_q) <= FIFO_SIZE);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        int'(occupancy_q) + (w_wr_en ? int'(w_chunk) : 0) <= FIFO_SIZE);
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        int'(occupancy_q) + (w_wr_en ? int'(w_chunk) : 0) >= (w_rd_en ? 1 : 0));
    a_len_legal: assert property (@(posedge clk) disable iff (!reset)
        (burst_valid_in && burst_ready_out) |-> (int'(burst_len_in) <= MAX_BURST));

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_sched
//  Description : Self-checking bench for fifo_wr_sched against a queue-based
//                reference model of the burst/chunk/occupancy rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_sched;

    localparam int FS  = 128;
    localparam int MBI = 16;
    localparam int MB  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [8*MB-1:0]  burst_data_in;
    logic [5:0]       burst_len_in;
    logic             burst_valid_in;
    logic             burst_ready_out;
    logic [8*MBI-1:0] fifo_data_out;
    logic [4:0]       fifo_num_bytes_out;
    logic             fifo_wr_en_out;
    logic             rd_req_in;
    logic             fifo_rd_en_out;
    logic [7:0]       occupancy_out;
    logic             busy_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bytes still to be written, byte count in FIFO, burst flag
    byte unsigned m_pend[$];
    int           m_occ;
    bit           m_busy;

    bit              e_ready, e_busy, e_wr, e_rd;
    int              e_num, e_occ;
    logic [8*MBI-1:0] e_data;

    fifo_wr_sched #(.FIFO_SIZE(FS), .MAX_BYTES_IN(MBI), .MAX_BURST(MB)) dut (
        .clk                (clk),
        .reset              (reset),
        .burst_data_in      (burst_data_in),
        .burst_len_in       (burst_len_in),
        .burst_valid_in     (burst_valid_in),
        .burst_ready_out    (burst_ready_out),
        .fifo_data_out      (fifo_data_out),
        .fifo_num_bytes_out (fifo_num_bytes_out),
        .fifo_wr_en_out     (fifo_wr_en_out),
        .rd_req_in          (rd_req_in),
        .fifo_rd_en_out     (fifo_rd_en_out),
        .occupancy_out      (occupancy_out),
        .busy_out           (busy_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend.delete();
        m_occ  = 0;
        m_busy = 0;
    endtask

    // Expected outputs of the current cycle from model state and current inputs
    task automatic predict();
        int ch;
        ch      = (m_pend.size() < MBI) ? m_pend.size() : MBI;
        e_ready = !m_busy;
        e_busy  = m_busy;
        e_wr    = m_busy && (ch <= FS - m_occ);
        e_num   = e_wr ? ch : 0;
        e_data  = '0;
        for (int i = 0; i < e_num; i++) e_data[8*i +: 8] = m_pend[i];
        e_rd    = rd_req_in && (m_occ > 0);
        e_occ   = m_occ;
    endtask

    // One clock: model takes the same edge as the DUT; returns at posedge+1
    task automatic advance();
        bit was_busy;
        predict();
        @(posedge clk);
        if (reset) begin
            was_busy = m_busy;
            for (int i = 0; i < e_num; i++) void'(m_pend.pop_front());
            m_occ = m_occ + e_num - (e_rd ? 1 : 0);
            if (was_busy) begin
                if (m_pend.size() == 0) m_busy = 0;
            end else if (burst_valid_in && burst_len_in != 6'd0) begin
                for (int i = 0; i < int'(burst_len_in); i++) m_pend.push_back(burst_data_in[8*i +: 8]);
                m_busy = 1;
            end
        end
        #1;
    endtask

    task automatic offer_seq(input int len, input int base);
        burst_data_in = '0;
        for (int i = 0; i < len; i++) burst_data_in[8*i +: 8] = 8'(base + i);
        burst_len_in   = 6'(len);
        burst_valid_in = 1'b1;
    endtask

    task automatic do_reset();
        burst_valid_in = 1'b0;
        burst_len_in   = '0;
        burst_data_in  = '0;
        rd_req_in      = 1'b0;
        reset          = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rd_req_in = 1'b1;
        burst_valid_in = 1'b0;
        burst_len_in = '0;
        burst_data_in = '0;
        model_reset();
        #3;
        n_cmp++; if (burst_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", burst_ready_out); end
        n_cmp++; if (fifo_wr_en_out !== 1'b0 || fifo_num_bytes_out !== 5'd0 || fifo_data_out !== '0) begin
            n_fail++; $display("FAIL reset_wr: got wr=%b n=%0d d=%h want 0/0/0", fifo_wr_en_out, fifo_num_bytes_out, fifo_data_out); end
        n_cmp++; if (fifo_rd_en_out !== 1'b0 || occupancy_out !== 8'd0 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_occ: got rd=%b occ=%0d busy=%b want 0/0/0", fifo_rd_en_out, occupancy_out, busy_out); end
        do_reset();
    endtask

    task automatic test_single_burst();
        logic [8*MBI-1:0] exp5;
        exp5 = 128'h15_14_13_12_11;
        do_reset();
        offer_seq(5, 8'h11);
        @(negedge clk);
        n_cmp++; if (burst_ready_out !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", burst_ready_out); end
        advance();
        burst_valid_in = 1'b0;
        @(negedge clk); predict();
        n_cmp++; if (fifo_wr_en_out !== 1'b1 || fifo_num_bytes_out !== 5'd5) begin
            n_fail++; $display("FAIL single_wr: got wr=%b n=%0d want 1/5", fifo_wr_en_out, fifo_num_bytes_out); end
        n_cmp++; if (fifo_data_out !== exp5 || fifo_data_out !== e_data) begin
            n_fail++; $display("FAIL single_data: got %h want %h", fifo_data_out, exp5); end
        advance();
        @(negedge clk);
        n_cmp++; if (occupancy_out !== 8'd5 || burst_ready_out !== 1'b1 || fifo_wr_en_out !== 1'b0) begin
            n_fail++; $display("FAIL single_after: got occ=%0d rdy=%b wr=%b want 5/1/0", occupancy_out, burst_ready_out, fifo_wr_en_out); end
    endtask

    task automatic test_two_chunk();
        logic [8*MBI-1:0] exp_lo, exp_hi;
        for (int i = 0; i < MBI; i++) begin exp_lo[8*i +: 8] = 8'(i); exp_hi[8*i +: 8] = 8'(i + 16); end
        do_reset();
        offer_seq(32, 0);
        advance();
        burst_valid_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_wr_en_out !== 1'b1 || fifo_num_bytes_out !== 5'd16 || fifo_data_out !== exp_lo) begin
            n_fail++; $display("FAIL two_chunk_1: got wr=%b n=%0d d=%h want 1/16/%h", fifo_wr_en_out, fifo_num_bytes_out, fifo_data_out, exp_lo); end
        advance();
        @(negedge clk);
        n_cmp++; if (fifo_wr_en_out !== 1'b1 || fifo_num_bytes_out !== 5'd16 || fifo_data_out !== exp_hi) begin
            n_fail++; $display("FAIL two_chunk_2: got wr=%b n=%0d d=%h want 1/16/%h", fifo_wr_en_out, fifo_num_bytes_out, fifo_data_out, exp_hi); end
        advance();
        @(negedge clk);
        n_cmp++; if (occupancy_out !== 8'd32 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL two_chunk_occ: got occ=%0d busy=%b want 32/0", occupancy_out, busy_out); end
    endtask

    task automatic test_stall();
        int lens[4] = '{32, 32, 32, 24};
        do_reset();
        foreach (lens[b]) begin
            offer_seq(lens[b], b * 40);
            advance();
            burst_valid_in = 1'b0;
            for (int k = 0; k < 8 && m_busy; k++) advance();
        end
        @(negedge clk);
        n_cmp++; if (occupancy_out !== 8'd120) begin n_fail++; $display("FAIL stall_preload: got occ=%0d want 120", occupancy_out); end
        offer_seq(16, 8'hA0);
        advance();
        burst_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (fifo_wr_en_out !== 1'b0 || busy_out !== 1'b1 || fifo_num_bytes_out !== 5'd0) begin
                n_fail++; $display("FAIL stall_hold%0d: got wr=%b busy=%b n=%0d want 0/1/0", k, fifo_wr_en_out, busy_out, fifo_num_bytes_out); end
            advance();
        end
        rd_req_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++; if (fifo_wr_en_out !== 1'b0 || fifo_rd_en_out !== 1'b1) begin
                n_fail++; $display("FAIL stall_read%0d: got wr=%b rd=%b want 0/1", k, fifo_wr_en_out, fifo_rd_en_out); end
            advance();
        end
        rd_req_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_wr_en_out !== 1'b1 || fifo_num_bytes_out !== 5'd16 || occupancy_out !== 8'd112) begin
            n_fail++; $display("FAIL stall_release: got wr=%b n=%0d occ=%0d want 1/16/112", fifo_wr_en_out, fifo_num_bytes_out, occupancy_out); end
        advance();
        @(negedge clk);
        n_cmp++; if (occupancy_out !== 8'd128 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL stall_full: got occ=%0d busy=%b want 128/0", occupancy_out, busy_out); end
    endtask

    task automatic test_read_gating();
        do_reset();
        rd_req_in = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_rd_en_out !== 1'b0) begin n_fail++; $display("FAIL gate_empty: got rd=%b want 0", fifo_rd_en_out); end
        advance();
        rd_req_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (occupancy_out !== 8'd0) begin n_fail++; $display("FAIL gate_occ0: got occ=%0d want 0", occupancy_out); end
        offer_seq(10, 8'h30);
        advance();
        burst_valid_in = 1'b0;
        advance();
        offer_seq(4, 8'h50);
        advance();
        burst_valid_in = 1'b0;
        rd_req_in = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_wr_en_out !== 1'b1 || fifo_rd_en_out !== 1'b1 || occupancy_out !== 8'd10) begin
            n_fail++; $display("FAIL gate_both: got wr=%b rd=%b occ=%0d want 1/1/10", fifo_wr_en_out, fifo_rd_en_out, occupancy_out); end
        advance();
        rd_req_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (occupancy_out !== 8'd13) begin n_fail++; $display("FAIL gate_13: got occ=%0d want 13", occupancy_out); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        offer_seq(32, 8'h40);
        advance();
        burst_valid_in = 1'b0;
        advance();
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (fifo_wr_en_out !== 1'b0 || occupancy_out !== 8'd0 || burst_ready_out !== 1'b1) begin
            n_fail++; $display("FAIL midrst_now: got wr=%b occ=%0d rdy=%b want 0/0/1", fifo_wr_en_out, occupancy_out, burst_ready_out); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (fifo_wr_en_out !== 1'b0 || occupancy_out !== 8'd0 || burst_ready_out !== 1'b1) begin
                n_fail++; $display("FAIL midrst_after%0d: got wr=%b occ=%0d rdy=%b want 0/0/1", k, fifo_wr_en_out, occupancy_out, burst_ready_out); end
            advance();
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        offer_seq(0, 0);
        burst_data_in = {8{$urandom()}};
        @(negedge clk);
        n_cmp++; if (burst_ready_out !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", burst_ready_out); end
        advance();
        burst_valid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (busy_out !== 1'b0 || fifo_wr_en_out !== 1'b0 || burst_ready_out !== 1'b1 || occupancy_out !== 8'd0) begin
                n_fail++; $display("FAIL zero_idle%0d: got busy=%b wr=%b rdy=%b occ=%0d want 0/0/1/0", k, busy_out, fifo_wr_en_out, burst_ready_out, occupancy_out); end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            burst_valid_in = ($urandom_range(0, 2) != 0);
            burst_len_in   = 6'($urandom_range(0, MB));
            for (int w = 0; w < 8; w++) burst_data_in[32*w +: 32] = $urandom();
            rd_req_in      = ($urandom_range(0, 9) < ((c / 150) % 2 == 0 ? 3 : 7));
            @(negedge clk); predict();
            n_cmp++;
            if ({fifo_wr_en_out, fifo_num_bytes_out, fifo_data_out, fifo_rd_en_out, occupancy_out, burst_ready_out, busy_out}
                !== {e_wr, 5'(e_num), e_data, e_rd, 8'(e_occ), e_ready, e_busy} || int'(occupancy_out) > FS) begin
                n_fail++;
                $display("FAIL random c=%0d: got wr=%b n=%0d d=%h rd=%b occ=%0d rdy=%b busy=%b want wr=%b n=%0d d=%h rd=%b occ=%0d rdy=%b busy=%b",
                         c, fifo_wr_en_out, fifo_num_bytes_out, fifo_data_out, fifo_rd_en_out, occupancy_out, burst_ready_out, busy_out,
                         e_wr, e_num, e_data, e_rd, e_occ, e_ready, e_busy);
            end
            advance();
        end
        burst_valid_in = 1'b0;
        rd_req_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_two_chunk();
        test_stall();
        test_read_gating();
        test_mid_reset();
        test_zero_len();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
- Write/read sequencer for the decompressor's multi-byte output byte FIFO.
- Accepts a burst of up to MAX_BURST decoded bytes on a valid/ready handshake and splits it into chunks of at most MAX_BYTES_IN bytes.
- Issues a chunk only when the FIFO has room for it; keeps its own occupancy shadow for that check.
- Gates consumer reads so the FIFO never underflows. Sits between the LZRW1 literal/copy expander (upstream) and the byte FIFO (downstream).

Parameters:
- FIFO_SIZE, 128, depth in bytes of the controlled FIFO.
- MAX_BYTES_IN, 16, width in bytes of the FIFO write port; max chunk size.
- MAX_BURST, 32, max bytes per upstream burst; must be >= MAX_BYTES_IN.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous reset, active-low.
- burst_data_in  in  8 x MAX_BURST  burst bytes; lane 0 is the first byte in stream order.
- burst_len_in  in  $clog2(MAX_BURST+1)  valid byte count, 0..MAX_BURST.
- burst_valid_in  in  1  burst offered.
- burst_ready_out  out  1  burst accepted when valid&ready.
- fifo_data_out  out  8 x MAX_BYTES_IN  chunk bytes to the FIFO; lane 0 first.
- fifo_num_bytes_out  out  $clog2(MAX_BYTES_IN+1)  chunk byte count.
- fifo_wr_en_out  out  1  chunk write strobe.
- rd_req_in  in  1  consumer requests one byte.
- fifo_rd_en_out  out  1  gated read strobe to the FIFO.
- occupancy_out  out  $clog2(FIFO_SIZE+1)  shadow byte count.
- busy_out  out  1  burst in progress.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; remaining=0, offset=0, occupancy=0; burst data register cleared.
  - Outputs: burst_ready_out=1, fifo_wr_en_out=0, fifo_num_bytes_out=0, fifo_data_out all 0, fifo_rd_en_out=0, busy_out=0.
  - A reset mid-burst discards the untransferred bytes. The FIFO shares the same reset, so the shadow occupancy and the FIFO stay consistent.
- State IDLE:
  - burst_ready_out=1, busy_out=0.
  - On valid&ready with len>0: latch data and len; offset=0; go to WRITE.
  - len=0: accepted and consumed; stay IDLE; no write.
- State WRITE:
  - burst_ready_out=0, busy_out=1.
  - chunk = min(remaining, MAX_BYTES_IN); free = FIFO_SIZE - occupancy, using the registered value (a same-cycle read is not credited).
  - If chunk <= free:
    - fifo_wr_en_out=1, fifo_num_bytes_out=chunk.
    - Lane i = burst byte offset+i for i<chunk; lanes >= chunk driven 0.
    - offset += chunk, remaining -= chunk.
    - remaining reaches 0 -> IDLE next cycle.
  - Else: stall with wr_en=0, num_bytes=0, data all 0; hold state.
- Timing:
  - Latency: burst accepted at edge T; first chunk is driven in cycle T+1.
  - N-byte burst with no stalls takes ceil(N/MAX_BYTES_IN) WRITE cycles.
  - After the last chunk, one IDLE cycle occurs before the next burst can be accepted.
- Reads:
  - fifo_rd_en_out = rd_req_in && occupancy != 0. This is combinational and independent of state.
  - rd_req_in while empty is dropped, not queued.
- Occupancy: occupancy_next = occupancy + (wr_en ? chunk : 0) - (rd_en ? 1 : 0).
  - Write and read in the same cycle are both applied.
  - Occupancy never exceeds FIFO_SIZE and never goes below 0.
  - Assertions flag a violation of either bound, and flag burst_len_in > MAX_BURST on acceptance.
- Pointer wrap-around is owned by the FIFO; this block only guarantees that chunk <= free at issue.
- Arithmetic: all counters are unsigned and sized to hold their maximum value plus 1; there is no modular wrap in occupancy.

Decomposition:
- Package fifo_sched_pkg:
  - sched_state_t enum {IDLE, WRITE}.
  - Width localparams BURST_LEN_W, CHUNK_W, OCC_W.
  - Function min_chunk(remaining) returning min(remaining, MAX_BYTES_IN).
- One natural sub-module: chunk_lane_shift, a combinational barrel shift that selects MAX_BYTES_IN lanes starting at offset and zeroes lanes >= chunk.
- The scheduler FSM, occupancy counter and read gating stay in fifo_wr_sched.

Test Plan:
- Reset then a 5-byte burst 0x11..0x15 with the FIFO empty -> next cycle wr_en=1, num_bytes=5, lanes 0..4 = 0x11..0x15, lanes 5..15 = 0; occupancy=5; ready back to 1 the following cycle.
- 32-byte burst (0x00..0x1F), no reads -> two writes of 16 bytes (lanes 0x00..0x0F, then 0x10..0x1F) in consecutive cycles; occupancy=32.
- Preload occupancy to 120 and no reads, then offer a 16-byte burst -> stall with wr_en=0 and busy=1. Pulse rd_req_in for 8 cycles -> when occupancy=112, a 16-byte write issues and occupancy becomes 128; full is never exceeded.
- rd_req_in=1 with occupancy=0 -> fifo_rd_en_out=0 and occupancy stays 0. Same-cycle 4-byte write plus read at occupancy 10 -> occupancy 13.
- Assert reset low mid-way through a 32-byte burst (after the first chunk) -> wr_en=0 immediately, occupancy=0, ready=1 after release; no further chunks are issued.
- len=0 burst -> accepted in one cycle, no wr_en, state stays IDLE.
